// File: rtl/lane_pkg.sv
// Shared types, constants and config derivation for the lane spawner.
package lane_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      SETUP   = 3'd2,
      STROBE1 = 3'd3,
      STROBE2 = 3'd4,
      FIN     = 3'd5
   } spawner_state_t;

   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam logic [2:0]  MAX_CAR_COUNT = 3'd4;
   localparam logic [2:0]  MAX_CAR_SPEED = 3'd7;
   localparam int unsigned CAR_WIDTH     = 48;
   localparam int unsigned CALC_W        = 5;

   // Payload carried on the shared lane configuration bus.
   typedef struct packed {
      logic       dir;
      logic [1:0] car_type;
      logic [2:0] count;
      logic [2:0] speed;
   } lane_cfg_t;

   // Derive a lane config from the low LFSR bits and the upper level bits, saturating.
   function automatic lane_cfg_t calc_cfg(input logic [5:0] r, input logic [2:0] lvl_hi);
      lane_cfg_t         cfg;
      logic [CALC_W-1:0] cnt;
      logic [CALC_W-1:0] spd;
      cnt = CALC_W'(r[4:3]) + CALC_W'(lvl_hi[2:1]);
      spd = CALC_W'(1) + CALC_W'(lvl_hi) + CALC_W'(r[5]);
      cfg.dir      = r[0];
      cfg.car_type = r[2:1];
      cfg.count    = (cnt > CALC_W'(MAX_CAR_COUNT)) ? MAX_CAR_COUNT : cnt[2:0];
      cfg.speed    = (spd > CALC_W'(MAX_CAR_SPEED)) ? MAX_CAR_SPEED : spd[2:0];
      return cfg;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR with advance enable; reusable random source.
module lfsr16
   import lane_pkg::*;
#(
   parameter logic [15:0] Seed = 16'hACE1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_adv,
   output logic [15:0] o_lfsr,
   output logic [15:0] o_next_c
);

   logic [15:0] r_lfsr;

   assign o_lfsr   = r_lfsr;
   assign o_next_c = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);

   // Step the LFSR only when asked; reset reloads the seed.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lfsr <= Seed;
      end else if (i_adv) begin
         r_lfsr <= o_next_c;
      end
   end

endmodule

// File: rtl/lane_spawner.sv
// Level-start controller: walks enabled lanes, drives the shared config bus, strobes SpawnEnable.
module lane_spawner
   import lane_pkg::*;
#(
   parameter int unsigned NumLanes = 10,
   parameter logic [15:0] Seed     = 16'hACE1
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                LevelStart,
   input  logic [3:0]          Level,
   input  logic [NumLanes-1:0] LaneMask,
   output logic [NumLanes-1:0] SpawnEnable,
   output logic                Direction,
   output logic [1:0]          CarType,
   output logic [2:0]          CarCount,
   output logic [2:0]          CarSpeed,
   output logic                Busy,
   output logic                Done
);

   localparam int unsigned      IDX_W    = (NumLanes > 1) ? $clog2(NumLanes) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NumLanes - 1);

   spawner_state_t      r_state;
   spawner_state_t      w_state_nxt;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic [3:0]          r_level;
   logic [NumLanes-1:0] r_mask;
   logic                w_latch;
   logic                w_adv;
   logic                w_lane_en;
   logic [15:0]         w_lfsr;
   logic [15:0]         w_lfsr_next;
   lane_cfg_t           r_cfg;
   lane_cfg_t           w_cfg_nxt;
   logic [NumLanes-1:0] w_spawn_nxt;
   logic                w_busy_nxt;
   logic                w_done_nxt;
   logic                w_unused;

   assign w_lane_en = r_mask[r_idx];
   assign w_unused  = ^{w_lfsr, w_lfsr_next[15:6], r_level[0]};

   lfsr16 #(.Seed(Seed)) u_lfsr (
      .i_clk    (Clk),
      .i_rst_n  (Reset_n),
      .i_adv    (w_adv),
      .o_lfsr   (w_lfsr),
      .o_next_c (w_lfsr_next)
   );

   // State, lane index and the request parameters captured at level start.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_level <= '0;
         r_mask  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_latch) begin
            r_level <= Level;
            r_mask  <= LaneMask;
         end
      end
   end

   // Sequence walk: masked lanes cost one cycle, enabled lanes four.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_latch     = 1'b0;
      w_adv       = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (LevelStart) begin
               w_state_nxt = LOAD;
               w_idx_nxt   = '0;
               w_latch     = 1'b1;
            end
         end
         LOAD: begin
            if (w_lane_en) begin
               w_adv       = 1'b1;
               w_state_nxt = SETUP;
            end else if (r_idx == LAST_IDX) begin
               w_state_nxt = FIN;
            end else begin
               w_idx_nxt = r_idx + IDX_W'(1);
            end
         end
         SETUP:   w_state_nxt = STROBE1;
         STROBE1: w_state_nxt = STROBE2;
         STROBE2: begin
            if (r_idx == LAST_IDX) begin
               w_state_nxt = FIN;
            end else begin
               w_idx_nxt   = r_idx + IDX_W'(1);
               w_state_nxt = LOAD;
            end
         end
         FIN:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Next output values, derived from the upcoming state so outputs register cleanly.
   always_comb begin
      w_spawn_nxt = '0;
      w_cfg_nxt   = r_cfg;
      w_busy_nxt  = (w_state_nxt != IDLE);
      w_done_nxt  = (w_state_nxt == FIN);
      if (w_state_nxt == STROBE1 || w_state_nxt == STROBE2) begin
         w_spawn_nxt = NumLanes'(1) << w_idx_nxt;
      end
      if (w_adv) begin
         w_cfg_nxt = calc_cfg(w_lfsr_next[5:0], r_level[3:1]);
      end
   end

   // Output registers; reset drops the strobe immediately.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         SpawnEnable <= '0;
         r_cfg       <= '0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
      end else begin
         SpawnEnable <= w_spawn_nxt;
         r_cfg       <= w_cfg_nxt;
         Busy        <= w_busy_nxt;
         Done        <= w_done_nxt;
      end
   end

   assign Direction = r_cfg.dir;
   assign CarType   = r_cfg.car_type;
   assign CarCount  = r_cfg.count;
   assign CarSpeed  = r_cfg.speed;

endmodule

// File: tb/tb_lane_spawner.sv
// Scoreboard bench for lane_spawner: stimulus queues expected strobes/Done, monitor checks them.
module tb_lane_spawner;

   localparam int unsigned N    = 10;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam logic [N-1:0] ALL = '1;

   logic         Clk = 1'b0;
   logic         Reset_n = 1'b1;
   logic         LevelStart = 1'b0;
   logic [3:0]   Level = '0;
   logic [N-1:0] LaneMask = '0;
   logic [N-1:0] SpawnEnable;
   logic         Direction;
   logic [1:0]   CarType;
   logic [2:0]   CarCount;
   logic [2:0]   CarSpeed;
   logic         Busy;
   logic         Done;

   lane_spawner #(.NumLanes(N), .Seed(SEED)) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .LevelStart  (LevelStart),
      .Level       (Level),
      .LaneMask    (LaneMask),
      .SpawnEnable (SpawnEnable),
      .Direction   (Direction),
      .CarType     (CarType),
      .CarCount    (CarCount),
      .CarSpeed    (CarSpeed),
      .Busy        (Busy),
      .Done        (Done)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int         lane;
      logic [8:0] cfg;
   } ev_t;

   ev_t         exp_ev[$];
   int          exp_done[$];
   int          checks = 0;
   int          errors = 0;
   int          edge_cnt = 0;
   int          base = 0;
   int          done_cnt = 0;
   int          spawn_cnt = 0;
   logic [15:0] m_lfsr = SEED;

   // monitor-private state
   logic        m_in_pulse = 1'b0;
   int          m_plen = 0;
   logic [8:0]  m_pcfg = '0;
   logic [N-1:0] m_pvec = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] r);
      return (r >> 1) ^ (r[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [8:0] model_cfg(input logic [15:0] r, input logic [3:0] lvl);
      int c;
      int s;
      c = int'(r[4:3]) + int'(lvl[3:2]);
      s = 1 + int'(lvl[3:1]) + int'(r[5]);
      if (c > 4) c = 4;
      if (s > 7) s = 7;
      return {r[0], r[2:1], 3'(c), 3'(s)};
   endfunction

   function automatic logic [8:0] bus();
      return {Direction, CarType, CarCount, CarSpeed};
   endfunction

   initial forever begin
      @(posedge Clk);
      edge_cnt++;
   end

   // Monitor: pops expectations whenever the DUT strobes a lane or pulses Done.
   initial forever begin
      @(negedge Clk);
      if (!Reset_n) begin
         m_in_pulse = 1'b0;
         exp_ev.delete();
         exp_done.delete();
      end else begin
         chk("spawn_onehot", 32'($onehot0(SpawnEnable)), 32'd1);
         if (SpawnEnable != '0) begin
            if (!m_in_pulse) begin
               int lane;
               lane = -1;
               for (int i = 0; i < int'(N); i++) if (SpawnEnable[i]) lane = i;
               m_in_pulse = 1'b1;
               m_plen     = 1;
               m_pcfg     = bus();
               m_pvec     = SpawnEnable;
               spawn_cnt++;
               chk("spawn_expected", 32'(exp_ev.size() > 0), 32'd1);
               if (exp_ev.size() > 0) begin
                  ev_t e;
                  e = exp_ev.pop_front();
                  chk("spawn_lane", 32'(lane), 32'(e.lane));
                  chk("spawn_cfg", 32'(bus()), 32'(e.cfg));
               end
            end else begin
               m_plen++;
               chk("bus_stable", 32'(bus()), 32'(m_pcfg));
               chk("spawn_same_lane", 32'(SpawnEnable), 32'(m_pvec));
            end
         end else if (m_in_pulse) begin
            m_in_pulse = 1'b0;
            chk("pulse_len", 32'(m_plen), 32'd2);
         end
         if (Done) begin
            done_cnt++;
            chk("done_expected", 32'(exp_done.size() > 0), 32'd1);
            chk("busy_at_done", 32'(Busy), 32'd1);
            if (exp_done.size() > 0) begin
               int d;
               d = exp_done.pop_front();
               chk("done_cycle", 32'(edge_cnt - base + 1), 32'(d));
            end
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_spawn"}, 32'(SpawnEnable), 32'd0);
      chk({tag, "_bus"}, 32'(bus()), 32'd0);
      chk({tag, "_busy"}, 32'(Busy), 32'd0);
      chk({tag, "_done"}, 32'(Done), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      #2 Reset_n = 1'b0;
      #1 check_zero("reset");
      m_lfsr = SEED;
      repeat (2) @(negedge Clk);
      #2 Reset_n = 1'b1;
   endtask

   task automatic push_model(input logic [3:0] lvl, input logic [N-1:0] mask);
      for (int i = 0; i < int'(N); i++) begin
         if (mask[i]) begin
            m_lfsr = lfsr_step(m_lfsr);
            exp_ev.push_back('{lane: i, cfg: model_cfg(m_lfsr, lvl)});
         end
      end
   endtask

   // Issue LevelStart; returns at the falling edge of cycle 1.
   task automatic launch(input logic [3:0] lvl, input logic [N-1:0] mask, input int done_cyc);
      exp_done.push_back(done_cyc);
      @(negedge Clk);
      Level      = lvl;
      LaneMask   = mask;
      LevelStart = 1'b1;
      @(posedge Clk);
      #1 base = edge_cnt;
      @(negedge Clk);
      LevelStart = 1'b0;
   endtask

   task automatic finish_seq(input int d0, input int s0, input int exp_spawns);
      int n;
      n = 0;
      while (done_cnt == d0 && n < 200) begin
         @(negedge Clk);
         #1 n++;
      end
      chk("done_seen", 32'(done_cnt > d0), 32'd1);
      @(negedge Clk);
      #1 chk("busy_after_done", 32'(Busy), 32'd0);
      repeat (4) @(negedge Clk);
      #1;
      chk("done_count", 32'(done_cnt - d0), 32'd1);
      chk("spawn_count", 32'(spawn_cnt - s0), 32'(exp_spawns));
      chk("ev_drained", 32'(exp_ev.size()), 32'd0);
   endtask

   task automatic check_lane0_first();
      repeat (2) @(negedge Clk);
      #1;
      chk("lane0_strobe", 32'(SpawnEnable), 32'h001);
      chk("lane0_cfg_hand", 32'(bus()), 32'(9'b0_00_010_010));
   endtask

   initial begin
      int d0;
      int s0;
      #1 Reset_n = 1'b0;
      #1 check_zero("por");
      m_lfsr = SEED;
      repeat (2) @(negedge Clk);
      #2 Reset_n = 1'b1;

      // Level 0, all lanes; lane 0 gets E270 -> dir 0, type 0, count 2, speed 2
      d0 = done_cnt; s0 = spawn_cnt;
      push_model(4'd0, ALL);
      launch(4'd0, ALL, 41);
      check_lane0_first();
      finish_seq(d0, s0, 10);

      // Level 15, all lanes: count saturates at 4 max, speed at 7
      d0 = done_cnt; s0 = spawn_cnt;
      push_model(4'd15, ALL);
      launch(4'd15, ALL, 41);
      finish_seq(d0, s0, 10);

      // Sparse mask 101, level 5: lane 0 from E270, lane 2 from 7138
      do_reset();
      d0 = done_cnt; s0 = spawn_cnt;
      exp_ev.push_back('{lane: 0, cfg: 9'b0_00_011_100});
      exp_ev.push_back('{lane: 2, cfg: 9'b0_00_100_100});
      launch(4'd5, 10'b0000000101, 17);
      finish_seq(d0, s0, 2);

      // LevelStart repeated mid-sequence is ignored
      do_reset();
      d0 = done_cnt; s0 = spawn_cnt;
      push_model(4'd3, ALL);
      launch(4'd3, ALL, 41);
      repeat (9) @(negedge Clk);
      Level      = 4'd0;
      LaneMask   = '0;
      LevelStart = 1'b1;
      @(negedge Clk);
      LevelStart = 1'b0;
      finish_seq(d0, s0, 10);

      // Reset during STROBE1 of lane 3, then the first run must repeat exactly
      do_reset();
      d0 = done_cnt;
      push_model(4'd0, ALL);
      launch(4'd0, ALL, 41);
      repeat (14) @(negedge Clk);
      #1 chk("lane3_strobe", 32'(SpawnEnable), 32'h008);
      #1 Reset_n = 1'b0;
      #1 check_zero("midrst");
      m_lfsr = SEED;
      repeat (2) @(negedge Clk);
      #2 Reset_n = 1'b1;
      chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
      chk("midrst_flushed", 32'(exp_ev.size()), 32'd0);
      d0 = done_cnt; s0 = spawn_cnt;
      push_model(4'd0, ALL);
      launch(4'd0, ALL, 41);
      check_lane0_first();
      finish_seq(d0, s0, 10);

      // All-zero mask: no strobes, Done in cycle 11
      d0 = done_cnt; s0 = spawn_cnt;
      launch(4'd2, '0, 11);
      finish_seq(d0, s0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/lane_spawner.md
# lane_spawner

Level-start controller for the road lanes. On a level start it walks every enabled lane in order and derives a pseudo-random car configuration (direction, type, count, speed) scaled by the level number. It drives that configuration onto a configuration bus shared by all lanes, then strobes that lane's `SpawnEnable`. It sits between the game-state FSM and the array of `lane` instances, and is the only driver of their `SpawnEnable`, `Direction`, `CarType`, `CarCount` and `CarSpeed` inputs.

## Interface
- `NumLanes`, 10: number of lane instances driven (1..16).
- `Seed`, 16'hACE1: LFSR reset value; must be nonzero.
- `Clk` input 1: single system clock; all state is on its rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `LevelStart` input 1: one-cycle request to (re)spawn all lanes.
- `Level` input 4: current level, sampled with `LevelStart`.
- `LaneMask` input NumLanes: 1 = lane participates; sampled with `LevelStart`.
- `SpawnEnable` output NumLanes: one-hot strobe; bit i feeds lane i.
- `Direction` output 1: shared config bus, 1 = cars face left.
- `CarType` output 2: shared config bus.
- `CarCount` output 3: shared config bus; lane spawns CarCount+1 cars (0..4).
- `CarSpeed` output 3: shared config bus (1..7).
- `Busy` output 1: sequence in progress.
- `Done` output 1: one-cycle pulse when the sequence completes.

## Operation
- All outputs are registered. Reset value of every output is 0; the LFSR resets to `Seed`, `Idx` to 0, and the state to IDLE.
- States:
  - IDLE: on `LevelStart`, latch `Level` and `LaneMask`, set `Idx`=0, go to LOAD. Otherwise stay.
  - LOAD:
    - If `Mask[Idx]`=0: skip the lane with no LFSR advance and no bus change. If `Idx`=NumLanes-1 go to FIN, else `Idx`++ and stay in LOAD.
    - If `Mask[Idx]`=1: advance the LFSR, compute the config from the new value `r`, register it onto the bus, and go to SETUP.
  - SETUP: bus stable, `SpawnEnable`=0; go to STROBE1.
  - STROBE1, STROBE2: `SpawnEnable[Idx]`=1, all other bits 0, bus unchanged. After STROBE2: if `Idx`=NumLanes-1 go to FIN, else `Idx`++ and go to LOAD.
  - FIN: `Done`=1 for this cycle; go to IDLE.
- LFSR: 16-bit Galois, right shift, taps 16'hB400. Next value = (r>>1) ^ (r[0] ? 16'hB400 : 0).
- Config from `r`; all arithmetic is at least 5 bits wide, saturating, with no wrap:
  - `Direction` = r[0]
  - `CarType` = r[2:1]
  - `CarCount` = min(r[4:3] + Level[3:2], 4)
  - `CarSpeed` = min(1 + Level[3:1] + r[5], 7)
- `LevelStart` while not in IDLE is ignored; the sequence is not restarted. It is accepted again in the cycle after `Done`.
- The config bus holds its last value while in IDLE.
- Reset mid-sequence: `SpawnEnable` drops immediately (asynchronously) and no `Done` is produced.

## Timing
- `LevelStart` is sampled at edge 0.
- `Busy` is 1 from edge 0 through the FIN cycle, and 0 after the edge that leaves FIN.
- Enabled lane, relative to its LOAD edge L: the bus is valid after L+1, `SpawnEnable[i]` rises after edge L+2 and falls after edge L+4. This gives a full cycle of setup before the lane's rising-edge capture.
- The bus changes no sooner than one cycle after `SpawnEnable` falls.
- Cost per enabled lane is 4 cycles; cost per masked lane is 1 cycle. FIN is one additional cycle.
- Full sequence with all NumLanes=10 lanes enabled: `Done` is high in cycle 41 after the `LevelStart` edge.
- All-zero mask: `Done` is high in cycle NumLanes+1, and `SpawnEnable` stays 0 throughout.
- `SpawnEnable` is never multi-hot.

## Structure
- Package `lane_pkg` holds:
  - `spawner_state_t` enum (IDLE, LOAD, SETUP, STROBE1, STROBE2, FIN)
  - `LFSR_TAPS`=16'hB400
  - `MAX_CAR_COUNT`=3'd4
  - `MAX_CAR_SPEED`=3'd7
  - `CAR_WIDTH`=48
- Sub-module `lfsr16` provides the Galois step with an advance enable, async active-low reset and `Seed` parameter. It is reusable for other random game elements.

## Test plan
- Reset, then `LevelStart` with `Level`=0, mask all ones, `Seed`=16'hACE1. The first LFSR value is 16'hE270, so lane 0 must receive Direction=0, CarType=0, CarCount=2, CarSpeed=2. The bus must be stable across the whole `SpawnEnable[0]` pulse.
- `Level`=15, mask all ones. Every lane must show CarCount ≤ 4 and CarSpeed = 7 (saturation), with `Done` in cycle 41.
- `LaneMask`=10'b0000000101. Only `SpawnEnable[0]` and `SpawnEnable[2]` pulse, each for 2 cycles. Lane 2 gets the LFSR's 2nd value, not its 3rd. `Done` comes in cycle 4+1+4+7+1=17.
- `LevelStart` reasserted in cycle 10 of a sequence: it is ignored, the `SpawnEnable` pattern is identical to an undisturbed run, and exactly one `Done` is produced.
- `Reset_n` low during STROBE1 of lane 3: all outputs are 0 immediately. After release, a new `LevelStart` reproduces the first-run sequence exactly (LFSR reseeded).
- All-zero mask: `SpawnEnable` is never nonzero and `Done` is high in cycle 11.
